// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver_if
// Description : Bundles the load/value bus and the scan outputs of
//               seg_scan_driver.
//               master : load source and display consumer
//               slave  : seg_scan_driver
// Signals     : load           - single-cycle capture strobe
//               value_in       - 4*NUM_DIGITS packed nibbles, digit 0 = LSN
//               hex_out        - nibble of the digit currently scanned
//               digit_sel      - one-hot active-high digit enable (or zero)
//               update_pending - captured value waits for frame boundary
//               frame_tick     - one-cycle pulse at the first cycle of slot 0
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [3:0]              hex_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    update_pending;
  logic                    frame_tick;

  modport master (
    output load,
    output value_in,
    input  hex_out,
    input  digit_sel,
    input  update_pending,
    input  frame_tick
  );

  modport slave (
    input  load,
    input  value_in,
    output hex_out,
    output digit_sel,
    output update_pending,
    output frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Multiplexed 7-segment scan driver. A prescaler divides clk
//               into digit slots; each slot starts with a blanking window
//               (all digits off) to suppress ghosting. New values are staged
//               in a pending register and applied only at a frame boundary
//               so a frame never shows a mix of old and new digits.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               bus   - seg_scan_driver_if.slave (load, value_in, hex_out,
//                       digit_sel, update_pending, frame_tick)
// Options     : SEG_SCAN_LZB_EN - leading-zero blanking: digits above 0
//               whose nibble and all higher nibbles are zero stay dark.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  seg_scan_driver_if.slave  bus
);

  localparam int c_PRESC_W = $clog2(SCAN_DIV);
  localparam int c_IDX_W   = $clog2(NUM_DIGITS);
  localparam int c_DATA_W  = 4 * NUM_DIGITS;

  logic [c_PRESC_W-1:0]  r_presc;
  logic [c_IDX_W-1:0]    r_idx;
  logic [c_DATA_W-1:0]   r_display;
  logic [c_DATA_W-1:0]   r_pending;
  logic                  r_update_pending;
  logic                  r_frame_tick;

  logic                  w_slot_end;
  logic                  w_frame_boundary;
  logic                  w_blank_window;
  logic [3:0]            w_hex;
  logic [NUM_DIGITS-1:0] w_sel;

  assign w_slot_end       = (r_presc == c_PRESC_W'(SCAN_DIV - 1));
  assign w_frame_boundary = w_slot_end && (r_idx == c_IDX_W'(NUM_DIGITS - 1));
  assign w_blank_window   = (r_presc < c_PRESC_W'(BLANK_CYCLES));

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_slot_end) begin
      r_presc <= '0;
      r_idx   <= w_frame_boundary ? '0 : r_idx + c_IDX_W'(1);
    end else begin
      r_presc <= r_presc + c_PRESC_W'(1);
    end
  end

  // Display / pending registers. A load coinciding with the boundary goes
  // straight to the display and supersedes any older staged value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display        <= '0;
      r_pending        <= '0;
      r_update_pending <= 1'b0;
    end else if (w_frame_boundary) begin
      if (bus.load) begin
        r_display <= bus.value_in;
      end else if (r_update_pending) begin
        r_display <= r_pending;
      end
      r_update_pending <= 1'b0;
    end else if (bus.load) begin
      r_pending        <= bus.value_in;
      r_update_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_boundary;
    end
  end

  // Current nibble select
  always_comb begin
    w_hex = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == c_IDX_W'(k)) begin
        w_hex = r_display[4*k +: 4];
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // w_upper_zero[k] is set when nibbles k..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS-1:0] w_upper_zero;
  logic                  w_run_zero;

  always_comb begin
    w_upper_zero = '0;
    w_run_zero   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run_zero      = w_run_zero && (r_display[4*k +: 4] == 4'h0);
      w_upper_zero[k] = w_run_zero;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      // Digit 0 is never blanked so a zero value still shows "0".
      w_sel[k] = !w_blank_window && (r_idx == c_IDX_W'(k)) &&
                 !((k > 0) && w_upper_zero[k]);
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_sel[k] = !w_blank_window && (r_idx == c_IDX_W'(k));
    end
  end
`endif

  assign bus.hex_out        = w_hex;
  assign bus.digit_sel      = w_sel;
  assign bus.update_pending = r_update_pending;
  assign bus.frame_tick     = r_frame_tick;

endmodule
`default_nettype wire
